// File: rtl/gfx_pkg.sv
// Shared fp32 types and constants for the vertex transform slice.
// Matrices are indexed [row][col].
package gfx_pkg;

  typedef logic [31:0] fp32_t;
  typedef fp32_t [3:0][3:0] mat4_t;

  localparam fp32_t FP32_ONE  = 32'h3F800000;
  localparam fp32_t FP32_ZERO = 32'h00000000;

  function automatic mat4_t mat4_identity();
    mat4_t m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[r][c] = (r == c) ? FP32_ONE : FP32_ZERO;
    return m;
  endfunction

  localparam mat4_t MAT4_IDENTITY = mat4_identity();

  // Leading-zero count of a 27-bit mantissa field (27 when zero).
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n   = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO.
// Head entry is visible on o_data whenever o_valid is high.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rd,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;

  assign w_wr    = i_wr && (r_count != CW'(DEPTH));
  assign w_rd    = i_rd && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage array, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_rd) r_rd_ptr <= nxt(r_rd_ptr);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/fp32_add.sv
// fp32 adder, round-to-nearest-even, denormals flushed to zero.
// Exact cancellation yields +0; result LATENCY cycles later.
module fp32_add
  import gfx_pkg::*;
#(
  parameter int LATENCY = 10
) (
  input  logic  i_clk,
  input  fp32_t i_a,
  input  fp32_t i_b,
  output fp32_t o_s
);

  fp32_t       w_big, w_sml, w_res;
  logic [7:0]  w_eb, w_es, w_d, w_e8;
  logic [4:0]  w_sh, w_lz;
  logic [26:0] w_mb, w_ms, w_ma, w_n;
  logic [53:0] w_t;
  logic [27:0] w_sum;
  logic [9:0]  w_e10;
  logic        w_g, w_st, w_up, w_uf;

  // Align smaller operand with sticky, add/sub, normalise, round.
  always_comb begin
    w_big = (i_b[30:0] > i_a[30:0]) ? i_b : i_a;
    w_sml = (i_b[30:0] > i_a[30:0]) ? i_a : i_b;
    w_eb  = w_big[30:23];
    w_es  = w_sml[30:23];
    w_mb  = (w_eb == 8'd0) ? 27'd0 : {1'b1, w_big[22:0], 3'b0};
    w_ms  = (w_es == 8'd0) ? 27'd0 : {1'b1, w_sml[22:0], 3'b0};
    w_d   = w_eb - w_es;
    w_sh  = (w_d > 8'd27) ? 5'd27 : w_d[4:0];
    w_t   = {w_ms, 27'b0} >> w_sh;
    w_ma  = {w_t[53:28], w_t[27] | (|w_t[26:0])};
    if (w_big[31] ^ w_sml[31])
      w_sum = {1'b0, w_mb} - {1'b0, w_ma};
    else
      w_sum = {1'b0, w_mb} + {1'b0, w_ma};
    w_lz = clz27(w_sum[26:0]);
    w_uf = 1'b0;
    if (w_sum[27]) begin
      w_n   = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e10 = {2'b00, w_eb} + 10'd1;
    end else begin
      w_n   = w_sum[26:0] << w_lz;
      w_e10 = {2'b00, w_eb} - {5'b0, w_lz};
      w_uf  = ({2'b00, w_eb} <= {5'b0, w_lz});
    end
    w_e8  = w_e10[7:0];
    w_g   = w_n[2];
    w_st  = |w_n[1:0];
    w_up  = w_g & (w_st | w_n[3]);
    w_res = {w_big[31], w_e8, w_n[25:3]} + {31'b0, w_up};
    if (w_sum == 28'd0)
      w_res = FP32_ZERO;
    else if (w_uf)
      w_res = {w_big[31], 31'b0};
    else if (w_e10 >= 10'd255)
      w_res = {w_big[31], 8'hFF, 23'b0};
  end

  pipe #(.WIDTH(32), .DEPTH(LATENCY)) u_pipe (
    .i_clk (i_clk),
    .i_rst (1'b0),
    .i_d   (w_res),
    .o_q   (o_s)
  );

endmodule

// File: rtl/fp32_mul.sv
// fp32 multiplier, round-to-nearest-even, denormals flushed to zero.
// Result appears LATENCY cycles after the operands.
module fp32_mul
  import gfx_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic  i_clk,
  input  fp32_t i_a,
  input  fp32_t i_b,
  output fp32_t o_p
);

  logic        w_s, w_g, w_st, w_up;
  logic [47:0] w_prod;
  logic [9:0]  w_e10;
  logic [7:0]  w_e8;
  logic [22:0] w_m;
  fp32_t       w_res;

  // Full-precision product, normalise by one bit, then round.
  always_comb begin
    w_s    = i_a[31] ^ i_b[31];
    w_prod = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
    w_e10  = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]}
           + {9'b0, w_prod[47]};
    if (w_prod[47]) begin
      w_m  = w_prod[46:24];
      w_g  = w_prod[23];
      w_st = |w_prod[22:0];
    end else begin
      w_m  = w_prod[45:23];
      w_g  = w_prod[22];
      w_st = |w_prod[21:0];
    end
    w_e8  = 8'(w_e10 - 10'd127);
    w_up  = w_g & (w_st | w_m[0]);
    w_res = {w_s, w_e8, w_m} + {31'b0, w_up};
    if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0)
      w_res = {w_s, 31'b0};
    else if (w_e10 <= 10'd127)
      w_res = {w_s, 31'b0};
    else if (w_e10 >= 10'd382)
      w_res = {w_s, 8'hFF, 23'b0};
  end

  pipe #(.WIDTH(32), .DEPTH(LATENCY)) u_pipe (
    .i_clk (i_clk),
    .i_rst (1'b0),
    .i_d   (w_res),
    .o_q   (o_p)
  );

endmodule

// File: rtl/pipe.sv
// Fixed-depth delay line; reset clears every stage.
// Used for tag/valid sideband and fp unit output staging.
module pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q [DEPTH];

  // Shift the input through DEPTH register stages.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) r_q[k] <= '0;
    end else begin
      r_q[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_q[k] <= r_q[k-1];
    end
  end

  assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/vertex_transform.sv
// Affine vertex transform: rows of a double-buffered 4x4 matrix
// times (x,y,z,1), credit flow control into an FWFT output FIFO.
module vertex_transform
  import gfx_pkg::*;
#(
  parameter int N_OUT       = 4,
  parameter int TAG_WIDTH   = 12,
  parameter int FIFO_DEPTH  = 32,
  parameter int MUL_LATENCY = 5,
  parameter int ADD_LATENCY = 10
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    mat_valid_in,
  input  logic [3:0][31:0]        mat_col_in,
  input  logic                    mat_commit_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [2:0][31:0]        vertex_in,
  input  logic [TAG_WIDTH-1:0]    tag_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [N_OUT-1:0][31:0]  vertex_out,
  output logic [TAG_WIDTH-1:0]    tag_out
);

  localparam int LAT = MUL_LATENCY + 2 * ADD_LATENCY;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int DW  = TAG_WIDTH + 32 * N_OUT;

  mat4_t                   r_shadow, r_active;
  logic [1:0]              r_col_idx;
  logic [CW-1:0]           r_credits;
  logic                    w_accept, w_pop, w_wr_valid;
  logic [TAG_WIDTH-1:0]    w_wr_tag;
  logic [TAG_WIDTH:0]      w_tag_q;
  logic [N_OUT-1:0][31:0]  w_result;
  logic [DW-1:0]           w_fifo_q;

  assign ready_out = (r_credits != '0);
  assign w_accept  = valid_in && ready_out;
  assign w_pop     = valid_out && ready_in;

  // Column loads go to shadow; commit publishes the pre-write shadow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_shadow  <= MAT4_IDENTITY;
      r_active  <= MAT4_IDENTITY;
      r_col_idx <= '0;
    end else begin
      if (mat_valid_in) begin
        for (int r = 0; r < 4; r++)
          r_shadow[r][r_col_idx] <= mat_col_in[r];
        r_col_idx <= r_col_idx + 2'd1;
      end
      if (mat_commit_in) begin
        r_active  <= r_shadow;
        r_col_idx <= '0;
      end
    end
  end

  // Credits = free FIFO slots not already claimed by in-flight work.
  always_ff @(posedge clk_in) begin
    if (rst_in)
      r_credits <= CW'(FIFO_DEPTH);
    else if (w_accept && !w_pop)
      r_credits <= r_credits - CW'(1);
    else if (!w_accept && w_pop)
      r_credits <= r_credits + CW'(1);
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_row
    fp32_t w_p [4];
    fp32_t w_s0, w_s1;

    fp32_mul #(.LATENCY(MUL_LATENCY)) u_mx (
      .i_clk(clk_in), .i_a(vertex_in[0]),
      .i_b(r_active[i][0]), .o_p(w_p[0]));
    fp32_mul #(.LATENCY(MUL_LATENCY)) u_my (
      .i_clk(clk_in), .i_a(vertex_in[1]),
      .i_b(r_active[i][1]), .o_p(w_p[1]));
    fp32_mul #(.LATENCY(MUL_LATENCY)) u_mz (
      .i_clk(clk_in), .i_a(vertex_in[2]),
      .i_b(r_active[i][2]), .o_p(w_p[2]));
    fp32_mul #(.LATENCY(MUL_LATENCY)) u_mw (
      .i_clk(clk_in), .i_a(FP32_ONE),
      .i_b(r_active[i][3]), .o_p(w_p[3]));

    fp32_add #(.LATENCY(ADD_LATENCY)) u_a0 (
      .i_clk(clk_in), .i_a(w_p[0]), .i_b(w_p[1]), .o_s(w_s0));
    fp32_add #(.LATENCY(ADD_LATENCY)) u_a1 (
      .i_clk(clk_in), .i_a(w_p[2]), .i_b(w_p[3]), .o_s(w_s1));
    fp32_add #(.LATENCY(ADD_LATENCY)) u_a2 (
      .i_clk(clk_in), .i_a(w_s0), .i_b(w_s1), .o_s(w_result[i]));
  end

  pipe #(.WIDTH(TAG_WIDTH + 1), .DEPTH(LAT)) u_tag (
    .i_clk (clk_in),
    .i_rst (rst_in),
    .i_d   ({w_accept, tag_in}),
    .o_q   (w_tag_q)
  );

  assign w_wr_valid = w_tag_q[TAG_WIDTH];
  assign w_wr_tag   = w_tag_q[TAG_WIDTH-1:0];

  fifo_sync #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_wr    (w_wr_valid),
    .i_data  ({w_wr_tag, w_result}),
    .i_rd    (w_pop),
    .o_valid (valid_out),
    .o_data  (w_fifo_q)
  );

  assign {tag_out, vertex_out} = w_fifo_q;

endmodule

// File: doc/vertex_transform.md
VERTEX_TRANSFORM -- requirements
Module: vertex_transform

Interface
REQ-001 SHALL have parameter N_OUT, default 4, number of output components (1..4), computed as rows 0..N_OUT-1 of a 4x4 matrix.
REQ-002 SHALL have parameter TAG_WIDTH, default 12, sideband tag width, e.g. material id.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, output buffer entries; must be >= LAT+2.
REQ-004 SHALL have parameters MUL_LATENCY, default 5, and ADD_LATENCY, default 10, which are the fp32_mul and fp32_add latencies.
REQ-005 SHALL have ports clk_in (input, 1): the single clock; rst_in (input, 1): synchronous, active-high reset.
REQ-006 SHALL have ports mat_valid_in (input, 1): write one column to the shadow matrix; mat_col_in (input, 4x32): column rows 0..3, fp32.
REQ-007 SHALL have port mat_commit_in (input, 1): copy the shadow matrix to the active matrix.
REQ-008 SHALL have ports valid_in (in, 1), ready_out (out, 1), vertex_in (in, 3x32: x, y, z fp32), tag_in (in, TAG_WIDTH).
REQ-009 SHALL have ports valid_out (out, 1), ready_in (in, 1), vertex_out (out, N_OUT x32), tag_out (out, TAG_WIDTH).

Function
REQ-010 SHALL compute out[i] = (x*A[i][0] + y*A[i][1]) + (z*A[i][2] + 1.0*A[i][3]) for each i < N_OUT, with A the active matrix, in this add-tree order.
REQ-011 SHALL use latency LAT = MUL_LATENCY + 2*ADD_LATENCY from accept to the FIFO write; tag_in SHALL travel a matched delay line.
REQ-012 SHALL accept a vertex when valid_in && ready_out, and drop no accepted vertex.
REQ-013 SHALL produce outputs in acceptance order.
REQ-014 SHALL compute ready_out as credits > 0. Credits count free FIFO slots minus vertices in flight:
  - decrement on accept;
  - increment on pop (valid_out && ready_in);
  - unchanged when both happen in the same cycle.
REQ-015 SHALL use a first-word-fall-through FIFO. On an empty FIFO, valid_out SHALL rise in cycle accept+LAT+1.
REQ-016 SHALL hold vertex_out and tag_out stable while valid_out && !ready_in.
REQ-017 SHALL write mat_col_in into shadow column col_idx on mat_valid_in, then increment col_idx (2 bits, wraps 3->0).
REQ-018 On mat_commit_in, SHALL copy shadow to active and clear col_idx to 0.
  - A same-cycle mat_valid_in write lands in shadow only and is excluded from the copy.
  - The same-cycle col_idx increment is overridden by the clear.
REQ-019 SHALL use the new active matrix for vertices accepted from the cycle after commit. Vertices accepted earlier SHALL use the old matrix.
REQ-020 SHALL not corrupt any in-flight result when a commit occurs with vertices in flight.

Reset
REQ-021 On rst_in, both matrices SHALL become identity (A[i][i]=32'h3F800000, others 0) and col_idx SHALL become 0.
REQ-022 On rst_in, credits SHALL become FIFO_DEPTH, FIFO and pipeline valids SHALL clear, valid_out SHALL be 0 and ready_out SHALL be 1 the cycle after reset deasserts.
REQ-023 Reset mid-stream SHALL discard all in-flight and buffered vertices, with no output emitted after reset.

Structure
REQ-024 Package gfx_pkg SHALL hold fp32_t, FP32_ONE (32'h3F800000), FP32_ZERO and the identity matrix constant.
REQ-025 SHALL instantiate 4*N_OUT fp32_mul and 3*N_OUT fp32_add, plus the existing pipe for the tag.
REQ-026 SHALL use one sub-module, fifo_sync (parameters WIDTH, DEPTH; FWFT), holding {tag, vertex}.

Verification
REQ-027 Identity after reset, vertex (3F800000,40000000,40400000) tag 5 -> out (3F800000,40000000,40400000,3F800000), tag 5, valid_out at cycle LAT+1.
REQ-028 Load cols 0..2 as identity and col3=(41200000,41A00000,41F00000,3F800000), commit, vertex (1,2,3) -> (41300000,41B00000,42040000,3F800000).
REQ-029 ready_in=0 with continuous valid_in -> exactly FIFO_DEPTH accepts, then ready_out=0. Release ready_in -> all outputs in order, none lost or duplicated.
REQ-030 Commit of the translate matrix between back-to-back vertices A and B (both (1,2,3)) -> A identity result, B translated result.
REQ-031 rst_in with 10 vertices in flight -> no valid_out afterwards, ready_out=1, and a subsequent vertex yields the identity result.
REQ-032 Simultaneous mat_valid_in and mat_commit_in -> the active matrix excludes that column, col_idx=0, and the next commit includes it.
